// File: rtl/brm_pkg.sv
// Shared defaults, rate typedef and trailing-ones helper for the binary rate multiplier.
package brm_pkg;
  localparam int BRM_W_DEF   = 16;
  localparam int BRM_NCH_DEF = 2;
  localparam int BRM_W_MAX   = 32;
  localparam int BRM_KW      = $clog2(BRM_W_MAX + 1);
  localparam int BRM_RATE_W  = BRM_W_DEF;

  typedef logic [BRM_RATE_W-1:0] brm_rate_t;

  // Counts ones from bit 0 up to the first zero. Callers zero-extend the counter,
  // so an all-ones W-bit value yields exactly W.
  function automatic logic [BRM_KW-1:0] brm_trailing_ones(input logic [BRM_W_MAX-1:0] v);
    logic [BRM_KW-1:0] n;
    logic              run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < BRM_W_MAX; i++) begin
      if (run && v[i]) n = n + BRM_KW'(1);
      else run = 1'b0;
    end
    return n;
  endfunction
endpackage

// File: rtl/brm_channel.sv
// One rate-multiplier channel: active rate, optional shadow/pending (BRM_SYNC_LOAD_EN),
// and the registered pulse bit selected by the shared weight index k.
module brm_channel
  import brm_pkg::*;
#(
  parameter int W = BRM_W_DEF
) (
  input  logic              ck,
  input  logic              rn,
  input  logic              en,
  input  logic              wrap,
  input  logic              ld_we,
  input  logic [BRM_KW-1:0] k,
  input  logic [W-1:0]      ld_rate,
  output logic              z,
  output logic              pending
);
  localparam int SELW = 2 ** BRM_KW;

  logic [W-1:0]    rate_reg;
  logic [SELW-1:0] sel_vec;
  logic            z_reg;

  // Bit-reversed rate padded with zeros: k=0 picks the MSB, k>=W picks nothing.
  generate
    for (genvar gi = 0; gi < SELW; gi++) begin : g_sel
      if (gi < W) begin : g_bit
        assign sel_vec[gi] = rate_reg[W-1-gi];
      end else begin : g_zero
        assign sel_vec[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) z_reg <= 1'b0;
    else     z_reg <= en & sel_vec[k];
  end

`ifdef BRM_SYNC_LOAD_EN
  logic [W-1:0] shadow_reg;
  logic         pending_reg;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      rate_reg    <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (ld_we) shadow_reg <= ld_rate;
      if (wrap) begin
        // A load accepted on the wrap step commits straight through.
        pending_reg <= 1'b0;
        if (ld_we)            rate_reg <= ld_rate;
        else if (pending_reg) rate_reg <= shadow_reg;
      end else if (ld_we) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign pending = pending_reg;
`else
  logic wrap_unused;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn)       rate_reg <= '0;
    else if (ld_we) rate_reg <= ld_rate;
  end

  assign wrap_unused = wrap;
  assign pending     = 1'b0;
`endif

  assign z = z_reg;
endmodule

// File: rtl/brm_rate_mult.sv
// Multi-channel binary rate multiplier: shared counter, terminal count and load decode.
// BRM_SYNC_LOAD_EN selects period-synchronous rate loads; default loads apply immediately.
module brm_rate_mult
  import brm_pkg::*;
#(
  parameter int W   = BRM_W_DEF,
  parameter int NCH = BRM_NCH_DEF,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CK,
  input  logic           RN,
  input  logic           EN,
  input  logic           LD_VALID,
  output logic           LD_READY,
  input  logic [CHW-1:0] LD_CH,
  input  logic [W-1:0]   LD_RATE,
  output logic [NCH-1:0] Z,
  output logic           TC,
  output logic [W-1:0]   CNT
);
  logic [W-1:0]      q_reg;
  logic              tc_reg;
  logic [BRM_KW-1:0] k;
  logic              wrap;
  logic              ld_fire;
  logic [NCH-1:0]    pending_vec;

  assign k        = brm_trailing_ones(BRM_W_MAX'(q_reg));
  assign wrap     = EN & (&q_reg);
  assign LD_READY = ~|pending_vec;
  assign ld_fire  = LD_VALID & LD_READY;

  // Channel numbers >= NCH match no instance, so such loads vanish without effect.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      brm_channel #(.W(W)) u_ch (
        .ck      (CK),
        .rn      (RN),
        .en      (EN),
        .wrap    (wrap),
        .ld_we   (ld_fire & (LD_CH == CHW'(gi))),
        .k       (k),
        .ld_rate (LD_RATE),
        .z       (Z[gi]),
        .pending (pending_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      q_reg  <= '0;
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= wrap;
      if (EN) q_reg <= q_reg + W'(1);
    end
  end

  assign TC  = tc_reg;
  assign CNT = q_reg;
endmodule

// File: tb/tb_brm_rate_mult.sv
// Self-checking bench for brm_rate_mult (W=4, NCH=3); follows BRM_SYNC_LOAD_EN when defined.
module tb_brm_rate_mult;
  localparam int W   = 4;
  localparam int NCH = 3;
  localparam int CHW = 2;

  logic           CK = 1'b0;
  logic           RN = 1'b0;
  logic           EN = 1'b0;
  logic           LD_VALID = 1'b0;
  logic           LD_READY;
  logic [CHW-1:0] LD_CH = '0;
  logic [W-1:0]   LD_RATE = '0;
  logic [NCH-1:0] Z;
  logic           TC;
  logic [W-1:0]   CNT;

  brm_rate_mult #(.W(W), .NCH(NCH)) dut (
    .CK(CK), .RN(RN), .EN(EN), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
    .LD_CH(LD_CH), .LD_RATE(LD_RATE), .Z(Z), .TC(TC), .CNT(CNT)
  );

  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  // Behavioural model: counter value, active/shadow rates, pending flags, expected outputs.
  int mq;
  int mrate[NCH];
  int mshadow[NCH];
  bit mpend[NCH];
  bit mz[NCH];
  bit mtc;
  int pz[NCH];
  int ptc;

  typedef struct {
    logic [3:0] r0;
    logic [3:0] r1;
    int         ncyc;
    int         p0;
    int         p1;
    int         ntc;
  } vec_t;
  vec_t tbl[4];

  function automatic bit mready();
    bit r = 1'b1;
    for (int c = 0; c < NCH; c++) if (mpend[c]) r = 1'b0;
    return r;
  endfunction

  // Step at counter value q selects rate bit W-1-(trailing ones of q); all-ones selects nothing.
  function automatic bit mpulse(int q, int rate);
    int k = 0;
    if (q == (1 << W) - 1) return 1'b0;
    while (((q >> k) & 1) == 1) k++;
    return ((rate >> (W - 1 - k)) & 1) == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic mreset();
    mq  = 0;
    mtc = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      mrate[c] = 0; mshadow[c] = 0; mpend[c] = 1'b0; mz[c] = 1'b0;
    end
  endtask

  task automatic clr_cnt();
    for (int c = 0; c < NCH; c++) pz[c] = 0;
    ptc = 0;
  endtask

  task automatic step(input bit en, input bit v, input int ch, input int r);
    bit acc;
    bit was_wrap;
    EN       = en;
    LD_VALID = v;
    LD_CH    = ch[CHW-1:0];
    LD_RATE  = r[W-1:0];
    @(posedge CK);
    acc      = v && mready() && (ch < NCH);
    was_wrap = en && (mq == (1 << W) - 1);
    for (int c = 0; c < NCH; c++) mz[c] = en && mpulse(mq, mrate[c]);
    mtc = was_wrap;
`ifdef BRM_SYNC_LOAD_EN
    if (acc) begin
      mshadow[ch] = r;
      mpend[ch]   = 1'b1;
    end
    if (was_wrap)
      for (int c = 0; c < NCH; c++)
        if (mpend[c]) begin
          mrate[c] = mshadow[c];
          mpend[c] = 1'b0;
        end
`else
    if (acc) mrate[ch] = r;
`endif
    if (en) mq = (mq + 1) % (1 << W);
    #1;
    chk("z", Z, {mz[2], mz[1], mz[0]});
    chk("tc", TC, mtc);
    chk("cnt", CNT, mq);
    chk("ld_ready", LD_READY, mready());
    for (int c = 0; c < NCH; c++) pz[c] += Z[c];
    ptc += TC;
  endtask

  task automatic do_reset();
    @(negedge CK);
    RN = 1'b0; EN = 1'b0; LD_VALID = 1'b0;
    #1;
    mreset();
    chk("rst_z", Z, 0);
    chk("rst_tc", TC, 0);
    chk("rst_cnt", CNT, 0);
    chk("rst_ready", LD_READY, 1);
    @(negedge CK);
    RN = 1'b1;
  endtask

  // Starts and ends with the counter at 0.
  task automatic load_rate(input int ch, input int r);
`ifdef BRM_SYNC_LOAD_EN
    step(1'b1, 1'b1, ch, r);
    repeat (15) step(1'b1, 1'b0, 0, 0);
`else
    step(1'b0, 1'b1, ch, r);
`endif
  endtask

  initial begin
    int n;
    bit req_v;
    int req_ch;
    int req_r;
    bit en;
    int q_before;

    tbl[0] = '{4'b1011, 4'b0001, 16, 11, 1, 1};
    tbl[1] = '{4'b0000, 4'b1111, 32, 0, 30, 2};
    tbl[2] = '{4'b0110, 4'b1000, 16, 6, 8, 1};
    tbl[3] = '{4'b1111, 4'b1111, 16, 15, 15, 1};
    mreset();
    clr_cnt();

    // Full-period pulse counts for a table of rate pairs.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      load_rate(0, int'(tbl[t].r0));
      load_rate(1, int'(tbl[t].r1));
      clr_cnt();
      for (int i = 0; i < tbl[t].ncyc; i++) begin
        q_before = mq;
        step(1'b1, 1'b0, 0, 0);
        if (q_before == 15) chk("z1_allones_step", Z[1], 0);
      end
      chk("period_p0", pz[0], tbl[t].p0);
      chk("period_p1", pz[1], tbl[t].p1);
      chk("period_tc", ptc, tbl[t].ntc);
    end

    // Random EN gaps with load traffic on other channels.
    do_reset();
    load_rate(0, 6);
    clr_cnt();
    n = 0;
    req_v = 1'b0; req_ch = 1; req_r = 0;
    for (int i = 0; i < 2000 && n < 64; i++) begin
      if (!req_v && $urandom_range(0, 3) == 0) begin
        req_v  = 1'b1;
        req_ch = $urandom_range(1, 3);
        req_r  = $urandom_range(0, 15);
      end
      en = ($urandom_range(0, 1) == 1);
      q_before = mq;
      if (req_v && mready()) begin
        step(en, 1'b1, req_ch, req_r);
        req_v = 1'b0;
      end else begin
        step(en, req_v, req_ch, req_r);
      end
      if (en) n++;
      else begin
        chk("z_after_gap", Z, 0);
        chk("cnt_hold", CNT, q_before);
      end
    end
    chk("en_steps", n, 64);
    chk("gap_pulses_ch0", pz[0], 24);

`ifdef BRM_SYNC_LOAD_EN
    // Load at q=3 is deferred to the wrap; a second request stalls until then.
    do_reset();
    load_rate(0, 3);
    clr_cnt();
    for (int i = 0; i < 16; i++) begin
      if (i < 3) step(1'b1, 1'b0, 0, 0);
      else if (i == 3) begin
        step(1'b1, 1'b1, 0, 8);
        chk("sync_ready_low", LD_READY, 0);
      end else step(1'b1, 1'b1, 1, 5);
    end
    chk("sync_old_count", pz[0], 3);
    chk("sync_ready_after_wrap", LD_READY, 1);
    clr_cnt();
    step(1'b1, 1'b1, 1, 5);
    chk("sync_second_accept", LD_READY, 0);
    repeat (15) step(1'b1, 1'b0, 0, 0);
    chk("sync_new_count", pz[0], 8);
    chk("sync_ch1_deferred", pz[1], 0);
`else
    // Immediate load: new rate visible two edges after acceptance.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8);
    chk("imm_ready", LD_READY, 1);
    chk("imm_z0_first", Z[0], 0);
    step(1'b1, 1'b0, 0, 0);
    chk("imm_z0_second", Z[0], 1);
    repeat (11) step(1'b1, 1'b0, 0, 0);
    chk("imm_cnt_zero", CNT, 0);
    clr_cnt();
    step(1'b1, 1'b1, 3, 15);
    repeat (15) step(1'b1, 1'b0, 0, 0);
    chk("imm_p0", pz[0], 8);
    chk("imm_discard_p1", pz[1], 0);
    chk("imm_discard_p2", pz[2], 0);
`endif

    // Asynchronous reset mid-period with a load in flight.
    do_reset();
    load_rate(0, 15);
    load_rate(1, 11);
    repeat (5) step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 2, 9);
    #2;
    RN = 1'b0;
    #1;
    chk("arst_z", Z, 0);
    chk("arst_tc", TC, 0);
    chk("arst_cnt", CNT, 0);
    chk("arst_ready", LD_READY, 1);
    mreset();
    @(negedge CK);
    RN = 1'b1;
    clr_cnt();
    repeat (16) step(1'b1, 1'b0, 0, 0);
    chk("arst_p0", pz[0], 0);
    chk("arst_p1", pz[1], 0);
    chk("arst_p2", pz[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
